// File: rtl/wb_arbiter_n.sv
// N-master Wishbone arbiter. It merges several independent master ports onto one
// shared slave bus. Arbitration is fixed-priority or round-robin, and a master
// keeps ownership for its whole cyc burst. A watchdog returns an error pulse to
// the owner when the slave stops acknowledging.
module wb_arbiter_n #(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int RR_MODE        = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_MASTERS-1:0]                m_cyc_i,
  input  logic [NUM_MASTERS-1:0]                m_stb_i,
  input  logic [NUM_MASTERS-1:0]                m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]     m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]     m_dat_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0]   m_sel_i,
  output logic [NUM_MASTERS-1:0]                m_ack_o,
  output logic [NUM_MASTERS-1:0]                m_err_o,
  output logic [DATA_WIDTH-1:0]                 m_dat_o,
  output logic                                  s_cyc_o,
  output logic                                  s_stb_o,
  output logic                                  s_we_o,
  output logic [ADDR_WIDTH-1:0]                 s_adr_o,
  output logic [DATA_WIDTH-1:0]                 s_dat_o,
  output logic [DATA_WIDTH/8-1:0]               s_sel_o,
  input  logic                                  s_ack_i,
  input  logic [DATA_WIDTH-1:0]                 s_dat_i,
  output logic [NUM_MASTERS-1:0]                grant_o,
  output logic                                  busy_o
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  // A zero timeout disables the watchdog; the counter is then kept one bit wide.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  // The error fires in the cycle that would make the count reach TIMEOUT_CYCLES.
  localparam logic [CW-1:0] WD_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                 state_r, state_s;
  logic [NUM_MASTERS-1:0] grant_r, grant_s;
  logic [PW-1:0]          rr_ptr_r, rr_ptr_s;
  logic [CW-1:0]          wd_cnt_r, wd_cnt_s;

  logic [NUM_MASTERS-1:0] win_s;
  logic [PW-1:0]          win_ptr_s;
  logic                   owner_cyc_s;
  logic                   wd_hit_s;

  // First requester at or after ptr, wrapping around to index 0.
  function automatic logic [NUM_MASTERS-1:0] pick_winner(
    input logic [NUM_MASTERS-1:0] req,
    input logic [PW-1:0]          ptr
  );
    logic [NUM_MASTERS-1:0] res;
    logic                   found;
    res   = '0;
    found = 1'b0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (!found && req[j] && (j >= int'(ptr))) begin
        res[j] = 1'b1;
        found  = 1'b1;
      end else begin
        res[j] = res[j];
      end
    end
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (!found && req[j]) begin
        res[j] = 1'b1;
        found  = 1'b1;
      end else begin
        res[j] = res[j];
      end
    end
    return res;
  endfunction

  // Pointer value following a one-hot winner (winner + 1, wrapping at N-1).
  function automatic logic [PW-1:0] next_ptr(input logic [NUM_MASTERS-1:0] win);
    logic [PW-1:0] nxt;
    nxt = '0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (win[j]) begin
        nxt = (j == NUM_MASTERS - 1) ? '0 : PW'(j + 1);
      end else begin
        nxt = nxt;
      end
    end
    return nxt;
  endfunction

  // Arbitration among the current requesters; fixed mode always searches from 0.
  always_comb begin
    win_s       = pick_winner(m_cyc_i, (RR_MODE != 0) ? rr_ptr_r : '0);
    win_ptr_s   = next_ptr(win_s);
    owner_cyc_s = |(grant_r & m_cyc_i);
  end

  // Slave-side mux: owner's signals pass through only while it owns the bus.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    if (state_r == OWN) begin
      for (int j = 0; j < NUM_MASTERS; j++) begin
        if (grant_r[j]) begin
          s_cyc_o = m_cyc_i[j];
          s_stb_o = m_stb_i[j];
          s_we_o  = m_we_i[j];
          s_adr_o = m_adr_i[j*ADDR_WIDTH +: ADDR_WIDTH];
          s_dat_o = m_dat_i[j*DATA_WIDTH +: DATA_WIDTH];
          s_sel_o = m_sel_i[j*SW +: SW];
        end else begin
          s_cyc_o = s_cyc_o;
        end
      end
    end else begin
      s_cyc_o = 1'b0;
    end
  end

  // Watchdog expiry: an ack in the same cycle suppresses the error.
  always_comb begin
    wd_hit_s = WD_EN && (state_r == OWN) && s_stb_o && !s_ack_i && (wd_cnt_r == WD_LAST);
  end

  // Next-state logic: grants, pointer update and watchdog count.
  always_comb begin
    state_s  = state_r;
    grant_s  = grant_r;
    rr_ptr_s = rr_ptr_r;
    wd_cnt_s = wd_cnt_r;
    case (state_r)
      IDLE: begin
        wd_cnt_s = '0;
        if (|m_cyc_i) begin
          grant_s  = win_s;
          rr_ptr_s = win_ptr_s;
          state_s  = OWN;
        end else begin
          grant_s  = '0;
        end
      end
      OWN: begin
        if (!owner_cyc_s) begin
          wd_cnt_s = '0;
          if (|m_cyc_i) begin
            grant_s  = win_s;
            rr_ptr_s = win_ptr_s;
            state_s  = OWN;
          end else begin
            grant_s  = '0;
            state_s  = IDLE;
          end
        end else if (wd_hit_s) begin
          wd_cnt_s = '0;
          state_s  = DRAIN;
        end else if (s_ack_i) begin
          wd_cnt_s = '0;
        end else if (s_stb_o) begin
          wd_cnt_s = wd_cnt_r + CW'(1);
        end else begin
          wd_cnt_s = wd_cnt_r;
        end
      end
      DRAIN: begin
        wd_cnt_s = '0;
        if (!owner_cyc_s) begin
          if (|m_cyc_i) begin
            grant_s  = win_s;
            rr_ptr_s = win_ptr_s;
            state_s  = OWN;
          end else begin
            grant_s  = '0;
            state_s  = IDLE;
          end
        end else begin
          state_s  = DRAIN;
        end
      end
      default: begin
        state_s  = IDLE;
        grant_s  = '0;
        wd_cnt_s = '0;
      end
    endcase
  end

  // State, grant, pointer and watchdog registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      grant_r  <= '0;
      rr_ptr_r <= '0;
      wd_cnt_r <= '0;
    end else begin
      state_r  <= state_s;
      grant_r  <= grant_s;
      rr_ptr_r <= rr_ptr_s;
      wd_cnt_r <= wd_cnt_s;
    end
  end

  // Responses: ack only to the owner while it owns; late acks in DRAIN are dropped.
  assign m_ack_o = (state_r == OWN) ? (grant_r & {NUM_MASTERS{s_ack_i}}) : '0;
  assign m_err_o = wd_hit_s ? grant_r : '0;
  assign m_dat_o = s_dat_i;
  assign grant_o = grant_r;
  assign busy_o  = |grant_r;

endmodule

// File: tb/tb_wb_arbiter_n.sv
// Directed bench for wb_arbiter_n: a fixed-priority 2-master instance driven from
// a per-cycle vector table, and a 4-master round-robin instance driven by hand sequences.
module tb_wb_arbiter_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  logic vec_bad;

  localparam logic [31:0] M0_ADR = 32'h0000_0100;
  localparam logic [31:0] M0_DAT = 32'hAAAA_5555;
  localparam logic [3:0]  M0_SEL = 4'b1111;
  localparam logic [31:0] M1_ADR = 32'h8000_0010;
  localparam logic [31:0] M1_DAT = 32'h1234_5678;
  localparam logic [3:0]  M1_SEL = 4'b0011;

  // Instance A: 2 masters, fixed priority, timeout 8
  logic        rst_a, sack_a, scyc_a, sstb_a, swe_a, busy_a;
  logic [1:0]  cyc_a, stb_a, we_a, ack_a, err_a, grant_a;
  logic [63:0] adr_a, dat_a;
  logic [7:0]  sel_a;
  logic [31:0] mdat_a, sadr_a, sdato_a, sdati_a;
  logic [3:0]  ssel_a;

  assign adr_a = {M1_ADR, M0_ADR};
  assign dat_a = {M1_DAT, M0_DAT};
  assign sel_a = {M1_SEL, M0_SEL};

  wb_arbiter_n #(.NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                 .RR_MODE(0), .TIMEOUT_CYCLES(8)) dut_a (
    .clk(clk), .reset(rst_a),
    .m_cyc_i(cyc_a), .m_stb_i(stb_a), .m_we_i(we_a),
    .m_adr_i(adr_a), .m_dat_i(dat_a), .m_sel_i(sel_a),
    .m_ack_o(ack_a), .m_err_o(err_a), .m_dat_o(mdat_a),
    .s_cyc_o(scyc_a), .s_stb_o(sstb_a), .s_we_o(swe_a),
    .s_adr_o(sadr_a), .s_dat_o(sdato_a), .s_sel_o(ssel_a),
    .s_ack_i(sack_a), .s_dat_i(sdati_a),
    .grant_o(grant_a), .busy_o(busy_a)
  );

  // Instance B: 4 masters, round-robin, timeout 8
  logic         rst_b, sack_b, scyc_b, sstb_b, swe_b, busy_b;
  logic [3:0]   cyc_b, ack_b, err_b, grant_b;
  logic [127:0] adr_b, dat_b;
  logic [15:0]  sel_b;
  logic [31:0]  mdat_b, sadr_b, sdato_b;
  logic [3:0]   ssel_b;

  assign adr_b = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0040};
  assign dat_b = 128'h0;
  assign sel_b = 16'hFFFF;

  wb_arbiter_n #(.NUM_MASTERS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                 .RR_MODE(1), .TIMEOUT_CYCLES(8)) dut_b (
    .clk(clk), .reset(rst_b),
    .m_cyc_i(cyc_b), .m_stb_i(cyc_b), .m_we_i(4'b0000),
    .m_adr_i(adr_b), .m_dat_i(dat_b), .m_sel_i(sel_b),
    .m_ack_o(ack_b), .m_err_o(err_b), .m_dat_o(mdat_b),
    .s_cyc_o(scyc_b), .s_stb_o(sstb_b), .s_we_o(swe_b),
    .s_adr_o(sadr_b), .s_dat_o(sdato_b), .s_sel_o(ssel_b),
    .s_ack_i(sack_b), .s_dat_i(32'h0000_0000),
    .grant_o(grant_b), .busy_o(busy_b)
  );

  // src: 0 = bus idle (all zero), 1 = master 0, 2 = master 1, 3 = don't check data path
  typedef struct {
    logic        rst;
    logic [1:0]  cyc, stb, we;
    logic        ack;
    logic [31:0] sdat;
    logic [1:0]  e_grant;
    logic        e_cyc, e_stb, e_we;
    logic [1:0]  e_ack, e_err, e_src;
  } vec_a_t;

  vec_a_t tab[$];

  function automatic vec_a_t mk(input logic rst, input logic [1:0] cyc, input logic [1:0] stb,
                                input logic [1:0] we, input logic ack, input logic [31:0] sdat,
                                input logic [1:0] eg, input logic ec, input logic es, input logic ew,
                                input logic [1:0] ea, input logic [1:0] ee, input logic [1:0] src);
    vec_a_t v;
    v.rst = rst; v.cyc = cyc; v.stb = stb; v.we = we; v.ack = ack; v.sdat = sdat;
    v.e_grant = eg; v.e_cyc = ec; v.e_stb = es; v.e_we = ew;
    v.e_ack = ea; v.e_err = ee; v.e_src = src;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      $display("FAIL vec %0d %s: got %h expected %h", vectors, name, act, exp);
      vec_bad = 1'b1;
    end
  endtask

  task automatic run_a(input vec_a_t v);
    logic [31:0] e_adr, e_dat;
    logic [3:0]  e_sel;
    rst_a = v.rst; cyc_a = v.cyc; stb_a = v.stb; we_a = v.we;
    sack_a = v.ack; sdati_a = v.sdat;
    #3;
    vec_bad = 1'b0;
    chk("a_grant", 32'(grant_a), 32'(v.e_grant));
    chk("a_busy",  32'(busy_a),  32'(|v.e_grant));
    chk("a_s_cyc", 32'(scyc_a),  32'(v.e_cyc));
    chk("a_s_stb", 32'(sstb_a),  32'(v.e_stb));
    chk("a_m_ack", 32'(ack_a),   32'(v.e_ack));
    chk("a_m_err", 32'(err_a),   32'(v.e_err));
    chk("a_m_dat", mdat_a,       v.sdat);
    case (v.e_src)
      2'd1:    begin e_adr = M0_ADR; e_dat = M0_DAT; e_sel = M0_SEL; end
      2'd2:    begin e_adr = M1_ADR; e_dat = M1_DAT; e_sel = M1_SEL; end
      default: begin e_adr = 32'h0;  e_dat = 32'h0;  e_sel = 4'h0;   end
    endcase
    if (v.e_src != 2'd3) begin
      chk("a_s_adr", sadr_a,        e_adr);
      chk("a_s_dat", sdato_a,       e_dat);
      chk("a_s_sel", 32'(ssel_a),   32'(e_sel));
      chk("a_s_we",  32'(swe_a),    32'(v.e_we));
    end
    vectors++;
    if (vec_bad) miscompares++;
    @(posedge clk); #1;
  endtask

  task automatic run_b(input logic rst, input logic [3:0] cyc, input logic ack,
                       input logic [3:0] eg, input logic [3:0] ea, input logic ec);
    logic [31:0] e_adr;
    rst_b = rst; cyc_b = cyc; sack_b = ack;
    #3;
    vec_bad = 1'b0;
    case (eg)
      4'b0001: e_adr = 32'h0000_0040;
      4'b0010: e_adr = 32'h1000_0000;
      4'b0100: e_adr = 32'h2000_0000;
      4'b1000: e_adr = 32'h3000_0000;
      default: e_adr = 32'h0;
    endcase
    chk("b_grant", 32'(grant_b), 32'(eg));
    chk("b_busy",  32'(busy_b),  32'(|eg));
    chk("b_m_ack", 32'(ack_b),   32'(ea));
    chk("b_m_err", 32'(err_b),   32'h0);
    chk("b_s_cyc", 32'(scyc_b),  32'(ec));
    chk("b_s_adr", sadr_b,       e_adr);
    vectors++;
    if (vec_bad) miscompares++;
    @(posedge clk); #1;
  endtask

  initial begin
    rst_a = 1'b1; cyc_a = 2'b00; stb_a = 2'b00; we_a = 2'b00; sack_a = 1'b0; sdati_a = 32'h0;
    rst_b = 1'b1; cyc_b = 4'b0000; sack_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // reset state, then single read by master 1 (ack 3 cycles after stb rises)
    tab.push_back(mk(1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0,          2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd0));
    tab.push_back(mk(1'b0, 2'b10, 2'b10, 2'b00, 1'b0, 32'h0,          2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd0));
    for (int i = 0; i < 3; i++)
      tab.push_back(mk(1'b0, 2'b10, 2'b10, 2'b00, 1'b0, 32'h0,        2'b10, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'd2));
    tab.push_back(mk(1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 32'hDEADBEEF,   2'b10, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 2'd2));
    tab.push_back(mk(1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0,          2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd2));
    tab.push_back(mk(1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0,          2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd0));
    // fixed priority: both request, master 0 first, then master 1 writes
    tab.push_back(mk(1'b0, 2'b11, 2'b11, 2'b10, 1'b0, 32'h0,          2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd0));
    tab.push_back(mk(1'b0, 2'b11, 2'b11, 2'b10, 1'b0, 32'h0,          2'b01, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'd1));
    tab.push_back(mk(1'b0, 2'b11, 2'b11, 2'b10, 1'b1, 32'hCAFE0001,   2'b01, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 2'd1));
    tab.push_back(mk(1'b0, 2'b10, 2'b10, 2'b10, 1'b0, 32'h0,          2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd1));
    tab.push_back(mk(1'b0, 2'b10, 2'b10, 2'b10, 1'b0, 32'h0,          2'b10, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 2'd2));
    tab.push_back(mk(1'b0, 2'b11, 2'b11, 2'b10, 1'b1, 32'h0,          2'b10, 1'b1, 1'b1, 1'b1, 2'b10, 2'b00, 2'd2));
    tab.push_back(mk(1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 32'h0,          2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd2));
    // timeout: master 0 strobes, slave silent; error in the 8th un-acked cycle
    for (int i = 0; i < 7; i++)
      tab.push_back(mk(1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 32'h0,        2'b01, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'd1));
    tab.push_back(mk(1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 32'h0,          2'b01, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01, 2'd1));
    tab.push_back(mk(1'b0, 2'b01, 2'b01, 2'b00, 1'b1, 32'h5A5A5A5A,   2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd3));
    tab.push_back(mk(1'b0, 2'b01, 2'b00, 2'b00, 1'b0, 32'h0,          2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd3));
    tab.push_back(mk(1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0,          2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd3));
    tab.push_back(mk(1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0,          2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd0));
    // reset while master 0 waits on the slave
    tab.push_back(mk(1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 32'h0,          2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd0));
    tab.push_back(mk(1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 32'h0,          2'b01, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'd1));
    tab.push_back(mk(1'b1, 2'b01, 2'b01, 2'b00, 1'b0, 32'h0,          2'b01, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'd1));
    tab.push_back(mk(1'b0, 2'b01, 2'b01, 2'b00, 1'b1, 32'h0,          2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd0));
    tab.push_back(mk(1'b0, 2'b01, 2'b01, 2'b00, 1'b0, 32'h0,          2'b01, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'd1));
    tab.push_back(mk(1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0,          2'b01, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd1));
    tab.push_back(mk(1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0,          2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd0));

    foreach (tab[i]) run_a(tab[i]);

    // ack arriving in the very cycle the watchdog would expire: ack wins, count restarts
    run_a(mk(1'b0, 2'b10, 2'b10, 2'b00, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd0));
    for (int i = 0; i < 7; i++)
      run_a(mk(1'b0, 2'b10, 2'b10, 2'b00, 1'b0, 32'h0, 2'b10, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'd2));
    run_a(mk(1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 32'h0, 2'b10, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 2'd2));
    for (int i = 0; i < 7; i++)
      run_a(mk(1'b0, 2'b10, 2'b10, 2'b00, 1'b0, 32'h0, 2'b10, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'd2));
    run_a(mk(1'b0, 2'b10, 2'b10, 2'b00, 1'b0, 32'h0, 2'b10, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 2'd2));
    run_a(mk(1'b0, 2'b10, 2'b10, 2'b00, 1'b0, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd3));
    run_a(mk(1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 2'b10, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd3));
    run_a(mk(1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'd0));

    // round-robin: four masters, single-beat transfers, each re-requests after release
    run_b(1'b0, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0);
    run_b(1'b0, 4'b1111, 1'b1, 4'b0001, 4'b0001, 1'b1);
    run_b(1'b0, 4'b1110, 1'b0, 4'b0001, 4'b0000, 1'b0);
    run_b(1'b0, 4'b1111, 1'b1, 4'b0010, 4'b0010, 1'b1);
    run_b(1'b0, 4'b1101, 1'b0, 4'b0010, 4'b0000, 1'b0);
    run_b(1'b0, 4'b1111, 1'b1, 4'b0100, 4'b0100, 1'b1);
    run_b(1'b0, 4'b1011, 1'b0, 4'b0100, 4'b0000, 1'b0);
    run_b(1'b0, 4'b1111, 1'b1, 4'b1000, 4'b1000, 1'b1);
    run_b(1'b0, 4'b0111, 1'b0, 4'b1000, 4'b0000, 1'b0);
    run_b(1'b0, 4'b0111, 1'b1, 4'b0001, 4'b0001, 1'b1);
    run_b(1'b0, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b0);
    run_b(1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);

    // wrap: pointer at 3 with requests at 0 and 3 -> 3 wins, then 0
    run_b(1'b1, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);
    run_b(1'b0, 4'b0100, 1'b0, 4'b0000, 4'b0000, 1'b0);
    run_b(1'b0, 4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b1);
    run_b(1'b0, 4'b0000, 1'b0, 4'b0100, 4'b0000, 1'b0);
    run_b(1'b0, 4'b1001, 1'b0, 4'b0000, 4'b0000, 1'b0);
    run_b(1'b0, 4'b1001, 1'b0, 4'b1000, 4'b0000, 1'b1);
    run_b(1'b0, 4'b0001, 1'b0, 4'b1000, 4'b0000, 1'b0);
    run_b(1'b0, 4'b1001, 1'b0, 4'b0001, 4'b0000, 1'b1);
    // reset mid-burst: pointer was 1, afterwards master 0 must win again from pointer 0
    run_b(1'b1, 4'b1001, 1'b0, 4'b0001, 4'b0000, 1'b1);
    run_b(1'b0, 4'b1001, 1'b1, 4'b0000, 4'b0000, 1'b0);
    run_b(1'b0, 4'b1001, 1'b0, 4'b0001, 4'b0000, 1'b1);
    run_b(1'b0, 4'b1000, 1'b0, 4'b0001, 4'b0000, 1'b0);
    run_b(1'b0, 4'b0000, 1'b0, 4'b1000, 4'b0000, 1'b0);
    run_b(1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_n.md
# wb_arbiter_n

Parametrised N-master Wishbone arbiter. It merges the CPU's independent Wishbone master ports onto one shared slave bus: the instruction-fetch master, the data-memory master, and future DMA or debug masters. Arbitration is either fixed-priority or round-robin, and ownership is held for a whole `cyc` burst. A bus-timeout watchdog returns an error to the owning master when the slave never acknowledges. The block sits between the CPU top and the SRAM/peripheral interconnect.

## Interface
Parameters:
- `NUM_MASTERS`, 2: number of master ports, 2..8.
- `ADDR_WIDTH`, 32: address width.
- `DATA_WIDTH`, 32: data width, a multiple of 8.
- `RR_MODE`, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- `TIMEOUT_CYCLES`, 255: number of un-acked strobe cycles before an error. 0 disables the watchdog. Counter width is `$clog2(TIMEOUT_CYCLES+1)`.

Ports:
- `clk` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `m_cyc_i` in N: per-master cycle.
- `m_stb_i` in N: per-master strobe.
- `m_we_i` in N: per-master write enable.
- `m_adr_i` in N·ADDR_WIDTH: master i occupies slice [i·AW +: AW].
- `m_dat_i` in N·DATA_WIDTH: write data, sliced the same way.
- `m_sel_i` in N·DATA_WIDTH/8: byte selects, sliced the same way.
- `m_ack_o` out N: ack, routed to the owner only.
- `m_err_o` out N: timeout error pulse, to the owner only.
- `m_dat_o` out DATA_WIDTH: read data, `s_dat_i` broadcast to all masters.
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1: slave-side control.
- `s_adr_o` out AW, `s_dat_o` out DW, `s_sel_o` out DW/8: slave-side address, data and selects.
- `s_ack_i` in 1, `s_dat_i` in DW: slave responses.
- `grant_o` out N: registered one-hot owner vector, all-zero when idle.
- `busy_o` out 1: high when any grant is held.

## Operation
- FSM states: IDLE, OWN, DRAIN.
- **IDLE:** if any `m_cyc_i` is high at a clock edge, choose a winner, register the one-hot `grant_o`, and go to OWN. Otherwise stay in IDLE.
- **Winner selection, fixed mode:** lowest requesting index.
- **Winner selection, round-robin mode:** first requester at or after pointer `rr_ptr`, wrapping from N-1 to 0. On each grant, `rr_ptr` becomes winner+1 mod N.
- **OWN, slave outputs:** `s_cyc_o`, `s_stb_o`, `s_we_o`, `s_adr_o`, `s_dat_o` and `s_sel_o` are the owner's inputs, gated combinationally by `grant_o`.
- **OWN, responses:** `m_ack_o[owner] = s_ack_i`. All other `m_ack_o` bits are 0.
- **OWN, release:** when the owner's `m_cyc_i` is sampled low at an edge, re-arbitrate at that same edge among current requesters. The releasing master is included but has `m_cyc_i` low, so it cannot win. Grant the new winner (stay in OWN) or go to IDLE with `grant_o` = 0.
- **OWN, ownership hold:** ownership is not preempted while the owner holds `m_cyc_i` high, even across multiple `stb` beats.
- **Watchdog count:** counts cycles in OWN with `s_stb_o`=1 and `s_ack_i`=0. It clears on `s_ack_i`, on a grant change and on leaving OWN.
- **Watchdog expiry:** in the cycle the count equals `TIMEOUT_CYCLES`, `m_err_o[owner]`=1 for exactly one cycle, then the FSM goes to DRAIN.
- **DRAIN:** `s_cyc_o`=`s_stb_o`=0 and all `m_ack_o`=0; a late `s_ack_i` is ignored. `grant_o` is held. When the owner's `m_cyc_i` is low, re-arbitrate exactly as on release from OWN.
- **No grant:** all `s_*` outputs are 0.
- **`m_dat_o`:** always equals `s_dat_i`.

## Timing
- **Reset:** takes effect on the next edge. The FSM goes to IDLE; `grant_o`, `rr_ptr`, the watchdog count and `busy_o` go to 0. All `s_*` and `m_ack_o`/`m_err_o` are 0 from the first cycle after reset. A reset during OWN or DRAIN abandons the transaction; no ack or err is issued for it.
- **Arbitration latency:** a request sampled in IDLE at edge k gives `s_cyc_o` high in cycle k+1.
- **Handover latency:** owner `cyc` sampled low at edge k gives the next master's `s_cyc_o` in cycle k+1. There are no dead cycles beyond this.
- **Ack/err path:** `m_ack_o` is combinational from `s_ack_i` (zero added latency). `m_err_o` is registered-state driven.
- **Simultaneous events:** an ack arriving in the same cycle the count reaches `TIMEOUT_CYCLES` wins. Ack is delivered, no err, and the count clears. Owner release and a new request at the same edge are resolved by a single arbitration.
- **Round-robin wrap:** with the pointer at N-1 and requests at 0 and N-1, N-1 wins and the pointer wraps to 0.

## Test plan
- **Single read:** N=2, master 1 reads `m_adr` 0x8000_0010. Slave acks 3 cycles after `s_stb_o` rises with 0xDEADBEEF. Required: `s_cyc_o` rises one cycle after the request; `m_ack_o`=2'b10 in the ack cycle; `m_dat_o`=0xDEADBEEF; `grant_o`=0 one cycle after `m_cyc_i[1]` drops.
- **Fixed priority:** N=2, `RR_MODE`=0, both masters request at the same edge. Required: `grant_o`=01 first; 10 in the cycle after master 0 drops `cyc`; master 1 never receives an ack during master 0's tenure.
- **Round-robin:** N=4, `RR_MODE`=1, all four masters issue back-to-back single-beat transactions with 1-cycle acks. Required grant sequence: 0001, 0010, 0100, 1000, 0001.
- **Timeout:** `TIMEOUT_CYCLES`=8, master 0 strobes and the slave never acks. Required: `m_err_o[0]` pulses exactly at the 8th un-acked stb cycle; `s_cyc_o`=0 from the next cycle; an `s_ack_i` injected in DRAIN gives `m_ack_o`=0.
- **Write passthrough:** master 1 writes 0x1234_5678 with `sel` 4'b0011. Required: `s_we_o`=1, `s_sel_o`=0011 and `s_dat_o`=0x1234_5678 while granted; master 0's bus values never appear on `s_*`.
- **Reset mid-burst:** assert `reset` for one cycle while master 0 owns the bus mid-wait. Required: next cycle `grant_o`=0 and `s_cyc_o`=0; with requests still pending after reset, arbitration restarts from `rr_ptr`=0.
